// File: rtl/divi_pipe_param.sv
// Pipelined restoring divider: AW/BW unsigned divide spread over STAGES ranks.
// Define DIVI_PIPE_ROUND_EN for a round-half-up quotient (default truncates).
module divi_pipe_param #(
    parameter int AW     = 48,
    parameter int BW     = 24,
    parameter int STAGES = 7,
    parameter int TW     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          vldin,
    input  logic [AW-1:0] ain,
    input  logic [BW-1:0] bin,
    input  logic [TW-1:0] tagin,
    output logic          vldout,
    output logic [AW-1:0] out,
    output logic [BW-1:0] remainder,
    output logic          dbz,
    output logic [TW-1:0] tagout
);

    localparam int NSEG = STAGES - 1;
    localparam int SPS  = (AW + NSEG - 1) / NSEG;

    // aq shifts dividend bits out of the top and quotient bits in at the bottom
    logic [AW-1:0] aq_r [NSEG];
    logic [BW-1:0] rm_r [NSEG];
    logic [BW-1:0] dv_r [NSEG];
    logic [TW-1:0] tg_r [NSEG];
    logic [NSEG-1:0] vld_r;

    logic [AW-1:0] aq_n [NSEG];
    logic [BW-1:0] rm_n [NSEG];

    logic [AW-1:0] q_fin;
    logic [BW-1:0] r_fin;
    logic [BW-1:0] d_fin;
    logic          zdiv;
    logic [AW-1:0] q_out;

    function automatic logic [AW+BW-1:0] div_step(
        input logic [AW-1:0] a,
        input logic [BW-1:0] m,
        input logic [BW-1:0] d
    );
        logic [BW:0] pr;
        logic        qb;
        pr = {m, a[AW-1]};
        qb = (pr >= {1'b0, d});
        if (qb) begin
            pr = pr - {1'b0, d};
        end
        return {a[AW-2:0], qb, pr[BW-1:0]};
    endfunction

    always_comb begin : seg_comb
        logic [AW-1:0] a;
        logic [BW-1:0] m;
        for (int s = 0; s < NSEG; s++) begin
            a = aq_r[s];
            m = rm_r[s];
            for (int k = 0; k < SPS; k++) begin
                if (s * SPS + k < AW) begin
                    {a, m} = div_step(a, m, dv_r[s]);
                end
            end
            aq_n[s] = a;
            rm_n[s] = m;
        end
    end

    assign q_fin = aq_n[NSEG-1];
    assign r_fin = rm_n[NSEG-1];
    assign d_fin = dv_r[NSEG-1];
    assign zdiv  = (d_fin == '0);

`ifdef DIVI_PIPE_ROUND_EN
    logic up;
    assign up    = ({r_fin, 1'b0} >= {1'b0, d_fin}) && !(&q_fin);
    assign q_out = q_fin + AW'(up);
`else
    assign q_out = q_fin;
`endif

    // data ranks carry don't-care payload when invalid, so they need no reset
    always_ff @(posedge clk) begin
        if (en) begin
            aq_r[0] <= ain;
            rm_r[0] <= '0;
            dv_r[0] <= bin;
            tg_r[0] <= tagin;
            for (int s = 1; s < NSEG; s++) begin
                aq_r[s] <= aq_n[s-1];
                rm_r[s] <= rm_n[s-1];
                dv_r[s] <= dv_r[s-1];
                tg_r[s] <= tg_r[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r     <= '0;
            vldout    <= 1'b0;
            out       <= '0;
            remainder <= '0;
            dbz       <= 1'b0;
            tagout    <= '0;
        end else if (en) begin
            vld_r[0] <= vldin;
            for (int s = 1; s < NSEG; s++) begin
                vld_r[s] <= vld_r[s-1];
            end
            vldout    <= vld_r[NSEG-1];
            out       <= zdiv ? '0 : q_out;
            remainder <= zdiv ? '0 : r_fin;
            dbz       <= zdiv;
            tagout    <= tg_r[NSEG-1];
        end
    end

endmodule

// File: doc/divi_pipe_param.md
DIVI_PIPE_PARAM -- requirements
Module: divi_pipe_param

Interface
REQ-001 Parameter AW, default 48: dividend and quotient width in bits, range 2..64.
REQ-002 Parameter BW, default 24: divisor and remainder width in bits, range 2..AW.
REQ-003 Parameter STAGES, default 7: total register ranks from input to output, range 2..AW+1.
REQ-004 Parameter TW, default 4: width of the sideband tag carried alongside each operation, range 1..16.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 en  input  1  global advance; when 0, every pipeline register holds its value.
REQ-008 vldin  input  1  input operands are valid.
REQ-009 ain  input  AW  unsigned dividend.
REQ-010 bin  input  BW  unsigned divisor.
REQ-011 tagin  input  TW  sideband tag, passed through unchanged.
REQ-012 vldout  output  1  registered; output fields are valid.
REQ-013 out  output  AW  registered; quotient.
REQ-014 remainder  output  BW  registered; remainder.
REQ-015 dbz  output  1  registered; divisor was zero.
REQ-016 tagout  output  TW  registered; the tag of the operation on the output.

Function
REQ-017 The block SHALL compute q = floor(ain/bin) and r = ain mod bin by restoring division, one quotient bit per step, MSB first, AW steps in total.
REQ-018 The AW steps SHALL be split into STAGES-1 combinational segments between ranks.
- Each segment except the last holds ceil(AW/(STAGES-1)) steps.
- The last segment holds the remainder of the steps.
REQ-019 Rank 1 SHALL register ain, bin, tagin and vldin.
- Ranks 2..STAGES-1 SHALL register the partial remainder, the quotient bits so far, the divisor, the tag and the valid bit.
- Rank STAGES SHALL be the output registers.
REQ-020 Latency SHALL be exactly STAGES cycles with en=1, from a vldin sample to the matching vldout.
REQ-021 Cycles with en=0 SHALL add to the latency one-for-one and SHALL NOT drop, duplicate or reorder operations.
REQ-022 Throughput SHALL be one operation per en=1 cycle; back-to-back vldin needs no idle cycles.
REQ-023 The valid bit SHALL travel with its data.
- Ranks holding vld=0 still update when en=1.
- Output fields carry don't-care values while vldout=0, except after reset (REQ-027).
REQ-024 Each step SHALL compare a partial remainder of BW+1 bits against {1'b0,bin}.
- If the divisor is less than or equal to the partial remainder, the step SHALL subtract it and emit quotient bit 1.
- Otherwise the step SHALL emit 0 and keep the partial remainder.
REQ-025 If bin=0, the output SHALL be out=0, remainder=0 and dbz=1. For bin!=0, dbz=0.
REQ-026 tagout SHALL equal the tagin sampled with the same operation.

Reset
REQ-027 When rst=1 at a rising edge, all valid bits in every rank SHALL clear to 0, and vldout, out, remainder, dbz and tagout SHALL clear to 0.
REQ-028 rst SHALL take priority over en.
- Operations in flight when reset is asserted are discarded and never produce vldout.
- The first vldin sampled after rst deasserts produces vldout STAGES en-cycles later.

Configuration
REQ-029 Macro DIVI_PIPE_ROUND_EN SHALL select the quotient rounding mode.
- Defined: out = q + 1 when 2*r >= bin, otherwise q (round-half-up).
- Defined: the +1 SHALL saturate at all-ones, and remainder still reports the truncated r.
- Undefined: out = q (truncation); no rounding logic is present.
- In both cases the dbz behaviour of REQ-025 is unchanged.

Verification (defaults AW=48, BW=24, STAGES=7, TW=4)
REQ-030 ain=100, bin=7, tag=3, en=1 -> 7 cycles later vldout=1, out=14, remainder=2, dbz=0, tagout=3, in both modes.
REQ-031 ain=10, bin=4 -> remainder=2; out=2 without DIVI_PIPE_ROUND_EN, out=3 with it. ain=2^48-1, bin=1 -> out=2^48-1, remainder=0 in both modes.
REQ-032 ain=12345, bin=0 -> out=0, remainder=0, dbz=1 after 7 cycles.
REQ-033 Throughput and stall:
- 20 back-to-back random operations with en held at 1 -> 20 consecutive vldout pulses, in order, all matching a reference model.
- Repeat with en=0 for 3 cycles mid-stream -> every result is delayed by exactly 3 cycles, none lost.
REQ-034 Reset mid-flight:
- Issue 4 operations, then assert rst for 1 cycle 3 cycles later -> no vldout for those 4, and all outputs read 0.
- A new operation issued on the cycle after reset -> vldout exactly 7 cycles later with correct values.
REQ-035 Parameter sweep AW=8, BW=4, STAGES=2 and STAGES=9: exhaustive ain/bin -> matches the reference model, latency equals STAGES.
